// File: rtl/dso_trig_capture.sv
// Hysteresis level trigger with selectable edge, feeding a circular-buffer sample RAM write port.
// Define DSO_AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT samples spent waiting.
module dso_trig_capture #(
  parameter int RAM_DEEP     = 1024,
  parameter int INPUT_WIDTH  = 12,
  parameter int HYST         = 20,
  parameter int AUTO_TIMEOUT = 65535,
  parameter int AW           = $clog2(RAM_DEEP)
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   sample_en,
  input  logic [INPUT_WIDTH-1:0] wave_in,
  input  logic [INPUT_WIDTH-1:0] trig_value,
  input  logic                   trig_edge,
  input  logic [AW-1:0]          pre_len,
  input  logic                   arm,
  output logic                   wr_en,
  output logic [AW-1:0]          wr_addr,
  output logic [INPUT_WIDTH-1:0] wr_data,
  output logic [AW-1:0]          trig_addr,
  output logic [AW-1:0]          start_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   auto_trig
);

  localparam int CW = INPUT_WIDTH + 1;
  localparam logic [CW-1:0] MAX_V = {1'b0, {INPUT_WIDTH{1'b1}}};

  if (((RAM_DEEP & (RAM_DEEP - 1)) != 0) || (AUTO_TIMEOUT < 1)) begin : g_bad_param
    $error("dso_trig_capture: RAM_DEEP must be a power of two and AUTO_TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   cmp_q, cmp_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [AW-1:0]          pre_len_q, pre_len_d;
  logic [AW-1:0]          pre_cnt_q, pre_cnt_d;
  logic [AW:0]            post_cnt_q, post_cnt_d;
  logic [AW-1:0]          trig_addr_q, trig_addr_d;
  logic [AW-1:0]          start_addr_q, start_addr_d;
  logic                   wr_en_q, wr_en_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [INPUT_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [CW-1:0] trig_ext, wave_ext, th_sum, th_hi, th_lo;
  logic          edge_evt;
  logic          active;
  logic          write_now;
  logic          trig_now;
  logic [AW:0]   post_target;
  logic [AW-1:0] pre_len_clamp;

`ifdef DSO_AUTO_TRIG_EN
  localparam int ACW = $clog2(AUTO_TIMEOUT + 1);
  logic [ACW-1:0] auto_cnt_q, auto_cnt_d;
  logic           auto_trig_q, auto_trig_d;
`endif

  // Thresholds carry one extra bit so the high side can saturate instead of wrapping.
  always_comb begin
    trig_ext = {1'b0, trig_value};
    wave_ext = {1'b0, wave_in};
    th_sum   = trig_ext + CW'(HYST);
    th_hi    = (th_sum > MAX_V) ? MAX_V : th_sum;
    th_lo    = (trig_ext >= CW'(HYST)) ? (trig_ext - CW'(HYST)) : '0;
  end

  always_comb begin
    cmp_d = cmp_q;
    if (sample_en) begin
      if (wave_ext > th_hi) begin
        cmp_d = 1'b1;
      end else if (wave_ext < th_lo) begin
        cmp_d = 1'b0;
      end
    end
  end

  assign edge_evt = sample_en & (trig_edge ? (cmp_q & ~cmp_d) : (~cmp_q & cmp_d));

  assign active        = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign write_now     = sample_en & active & ~arm;
  assign post_target   = (AW + 1)'(RAM_DEEP) - {1'b0, pre_len_q};
  assign pre_len_clamp = (32'(pre_len) > (RAM_DEEP - 1)) ? AW'(RAM_DEEP - 1) : pre_len;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    pre_len_d    = pre_len_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    trig_now     = 1'b0;
`ifdef DSO_AUTO_TRIG_EN
    auto_cnt_d   = auto_cnt_q;
    auto_trig_d  = auto_trig_q;
`endif

    // arm outranks any trigger or count completion seen in the same cycle
    if (arm) begin
      pre_len_d  = pre_len_clamp;
      pre_cnt_d  = '0;
      post_cnt_d = '0;
      state_d    = (pre_len_clamp == '0) ? S_WAIT : S_PRE;
`ifdef DSO_AUTO_TRIG_EN
      auto_cnt_d  = '0;
      auto_trig_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_PRE: begin
          if (sample_en) begin
            pre_cnt_d = pre_cnt_q + AW'(1);
            if (pre_cnt_d == pre_len_q) begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (sample_en) begin
            trig_now = edge_evt;
`ifdef DSO_AUTO_TRIG_EN
            if (!edge_evt) begin
              if ((auto_cnt_q + ACW'(1)) == ACW'(AUTO_TIMEOUT)) begin
                trig_now    = 1'b1;
                auto_trig_d = 1'b1;
              end else begin
                auto_cnt_d = auto_cnt_q + ACW'(1);
              end
            end
`endif
            if (trig_now) begin
              trig_addr_d  = ptr_q;
              start_addr_d = ptr_q - pre_len_q;
              post_cnt_d   = (AW + 1)'(1);
              // The trigger sample alone can complete the record when pre_len_q is maximal.
              state_d      = (post_target == (AW + 1)'(1)) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_en) begin
            post_cnt_d = post_cnt_q + (AW + 1)'(1);
            if (post_cnt_d == post_target) begin
              state_d = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end

    if (write_now) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ptr_q;
      wr_data_d = wave_in;
      ptr_d     = ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmp_q        <= 1'b0;
      ptr_q        <= '0;
      pre_len_q    <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmp_q        <= cmp_d;
      ptr_q        <= ptr_d;
      pre_len_q    <= pre_len_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

`ifdef DSO_AUTO_TRIG_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
    end else begin
      auto_cnt_q  <= auto_cnt_d;
      auto_trig_q <= auto_trig_d;
    end
  end

  assign auto_trig = auto_trig_q;
`else
  assign auto_trig = 1'b0;
`endif

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;
  assign busy       = active;
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_dso_trig_capture.sv
// Directed bench for dso_trig_capture: expected RAM writes queued at stimulus time,
// popped and compared by a monitor on every wr_en; status outputs checked inline.
module tb_dso_trig_capture;

  localparam int RAM_DEEP     = 16;
  localparam int INPUT_WIDTH  = 12;
  localparam int HYST         = 2;
  localparam int AUTO_TIMEOUT = 8;
  localparam int AW           = 4;

  logic                   clk_in     = 1'b0;
  logic                   rst_n      = 1'b0;
  logic                   sample_en  = 1'b0;
  logic [INPUT_WIDTH-1:0] wave_in    = '0;
  logic [INPUT_WIDTH-1:0] trig_value = '0;
  logic                   trig_edge  = 1'b0;
  logic [AW-1:0]          pre_len    = '0;
  logic                   arm        = 1'b0;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [INPUT_WIDTH-1:0] wr_data;
  logic [AW-1:0]          trig_addr;
  logic [AW-1:0]          start_addr;
  logic                   busy;
  logic                   done;
  logic                   auto_trig;

  int checks = 0;
  int errors = 0;
  logic [AW+INPUT_WIDTH-1:0] exp_q[$];
  logic [AW-1:0] tb_ptr = '0;

  dso_trig_capture #(
    .RAM_DEEP    (RAM_DEEP),
    .INPUT_WIDTH (INPUT_WIDTH),
    .HYST        (HYST),
    .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sample_en (sample_en),
    .wave_in   (wave_in),
    .trig_value(trig_value),
    .trig_edge (trig_edge),
    .pre_len   (pre_len),
    .arm       (arm),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .trig_addr (trig_addr),
    .start_addr(start_addr),
    .busy      (busy),
    .done      (done),
    .auto_trig (auto_trig)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs; queue the write this sample should produce.
  task automatic step(input logic a, input logic se, input logic [INPUT_WIDTH-1:0] w, input bit wr);
    arm       = a;
    sample_en = se;
    wave_in   = w;
    if (wr) begin
      exp_q.push_back({tb_ptr, w});
      tb_ptr = tb_ptr + 4'd1;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic run(input int n, input logic [INPUT_WIDTH-1:0] w, input bit wr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, w, wr);
  endtask

  task automatic arm_capture(input logic [AW-1:0] pl);
    pre_len = pl;
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic strobe(input logic [INPUT_WIDTH-1:0] w);
    step(1'b0, 1'b1, w, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'd200, 1'b0);
  endtask

  always @(negedge clk_in) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", wr_addr, wr_data);
      end else begin
        logic [AW+INPUT_WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[AW+INPUT_WIDTH-1:INPUT_WIDTH]));
        chk("wr_data", 32'(wr_data), 32'(e[INPUT_WIDTH-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [INPUT_WIDTH-1:0] osc [8];
    logic [INPUT_WIDTH-1:0] pre3 [8];
    osc  = '{12'd94, 12'd98, 12'd94, 12'd98, 12'd95, 12'd97, 12'd95, 12'd97};
    pre3 = '{12'd99, 12'd99, 12'd50, 12'd99, 12'd99, 12'd99, 12'd99, 12'd99};

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    chk("rst_start_addr", 32'(start_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_auto_trig", 32'(auto_trig), 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);

    // Rising ramp: trigger on 100 at addr 10, record starts at 6
    trig_value = 12'd95;
    trig_edge  = 1'b0;
    arm_capture(4'd4);
    chk("t1_busy_pre", 32'(busy), 1);
    for (int i = 0; i < 22; i++) begin
      step(1'b0, 1'b1, 12'(i * 10), 1'b1);
      if (i == 10) begin
        chk("t1_trig_addr", 32'(trig_addr), 10);
        chk("t1_start_addr", 32'(start_addr), 6);
      end
      if (i == 20) chk("t1_done_early", 32'(done), 0);
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_low", 32'(busy), 0);
    run(2, 12'd0, 1'b0);
    chk("t1_done_held", 32'(done), 1);
    chk("t1_queue", exp_q.size(), 0);

    // Hysteresis band: 94..98 around 96 never triggers, 99 does
    trig_value = 12'd96;
    arm_capture(4'd2);
    run(2, 12'd90, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, osc[i], 1'b1);
    chk("t2_no_trig_busy", 32'(busy), 1);
    chk("t2_no_trig_addr", 32'(trig_addr), 10);
    step(1'b0, 1'b1, 12'd99, 1'b1);
    chk("t2_trig_addr", 32'(trig_addr), 0);
    chk("t2_start_addr", 32'(start_addr), 14);
    run(12, 12'd99, 1'b1);
    chk("t2_done_early", 32'(done), 0);
    run(1, 12'd99, 1'b1);
    chk("t2_done", 32'(done), 1);

    // Falling edge: ignored in PRE, honoured in WAIT
    trig_edge = 1'b1;
    arm_capture(4'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, pre3[i], 1'b1);
    chk("t3_busy_after_pre", 32'(busy), 1);
    step(1'b0, 1'b1, 12'd99, 1'b1);
    step(1'b0, 1'b1, 12'd99, 1'b1);
    step(1'b0, 1'b1, 12'd50, 1'b1);
    chk("t3_trig_addr", 32'(trig_addr), 8);
    chk("t3_start_addr", 32'(start_addr), 0);
    run(6, 12'd50, 1'b1);
    chk("t3_done_early", 32'(done), 0);
    run(1, 12'd50, 1'b1);
    chk("t3_done", 32'(done), 1);

    // pre_len = 0: straight to WAIT, trigger sample starts the record
    trig_edge  = 1'b0;
    trig_value = 12'd95;
    arm_capture(4'd0);
    chk("t4_busy", 32'(busy), 1);
    step(1'b0, 1'b1, 12'd10, 1'b1);
    step(1'b0, 1'b1, 12'd20, 1'b1);
    step(1'b0, 1'b1, 12'd100, 1'b1);
    chk("t4_trig_addr", 32'(trig_addr), 2);
    chk("t4_start_addr", 32'(start_addr), 2);
    run(14, 12'd100, 1'b1);
    chk("t4_done_early", 32'(done), 0);
    run(1, 12'd100, 1'b1);
    chk("t4_done", 32'(done), 1);

    // Maximum pre_len (port is AW bits so 15 is the clamp ceiling): one post write
    step(1'b0, 1'b1, 12'd0, 1'b0);
    arm_capture(4'd15);
    run(15, 12'd0, 1'b1);
    chk("t5_busy", 32'(busy), 1);
    step(1'b0, 1'b1, 12'd100, 1'b1);
    chk("t5_trig_addr", 32'(trig_addr), 1);
    chk("t5_start_addr", 32'(start_addr), 2);
    chk("t5_done", 32'(done), 1);
    chk("t5_busy_low", 32'(busy), 0);

    // Saturated upper threshold: full-scale input cannot trigger
    trig_value = 12'd4094;
    step(1'b0, 1'b1, 12'd0, 1'b0);
    arm_capture(4'd2);
    run(2, 12'd0, 1'b1);
    run(10, 12'd4095, 1'b1);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_done", 32'(done), 0);
    chk("t6_trig_addr", 32'(trig_addr), 1);

    // Asynchronous reset mid-WAIT
    #5;
    rst_n = 1'b0;
    #1;
    chk("t7_wr_en", 32'(wr_en), 0);
    chk("t7_wr_addr", 32'(wr_addr), 0);
    chk("t7_wr_data", 32'(wr_data), 0);
    chk("t7_trig_addr", 32'(trig_addr), 0);
    chk("t7_start_addr", 32'(start_addr), 0);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_done", 32'(done), 0);
    chk("t7_queue", exp_q.size(), 0);
    tb_ptr = '0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    chk("t7_idle_busy", 32'(busy), 0);

    // Restart mid-POST: ptr continues, done never rises for the aborted record
    trig_value = 12'd95;
    arm_capture(4'd2);
    run(2, 12'd0, 1'b1);
    step(1'b0, 1'b1, 12'd100, 1'b1);
    chk("t8_trig_addr_a", 32'(trig_addr), 2);
    chk("t8_start_addr_a", 32'(start_addr), 0);
    run(3, 12'd100, 1'b1);
    pre_len = 4'd3;
    step(1'b1, 1'b1, 12'd100, 1'b0);
    chk("t8_done_after_rearm", 32'(done), 0);
    chk("t8_busy_after_rearm", 32'(busy), 1);
    run(3, 12'd0, 1'b1);
    step(1'b0, 1'b1, 12'd100, 1'b1);
    chk("t8_trig_addr_b", 32'(trig_addr), 9);
    chk("t8_start_addr_b", 32'(start_addr), 6);
    run(11, 12'd100, 1'b1);
    chk("t8_done_early", 32'(done), 0);
    run(1, 12'd100, 1'b1);
    chk("t8_done", 32'(done), 1);

    // Quarter-rate sample_en: only strobed samples reach the RAM or the comparator
    step(1'b0, 1'b1, 12'd0, 1'b0);
    arm_capture(4'd1);
    strobe(12'd0);
    strobe(12'd0);
    step(1'b0, 1'b1, 12'd100, 1'b1);
    chk("t9_trig_addr", 32'(trig_addr), 8);
    chk("t9_start_addr", 32'(start_addr), 7);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 12'd200, 1'b0);
    for (int i = 0; i < 13; i++) strobe(12'd100);
    chk("t9_done_early", 32'(done), 0);
    step(1'b0, 1'b1, 12'd100, 1'b1);
    chk("t9_done", 32'(done), 1);
    step(1'b0, 1'b0, 12'd0, 1'b0);

    // Constant input: forced trigger only with the auto-trigger build
`ifdef DSO_AUTO_TRIG_EN
    arm_capture(4'd2);
    run(2, 12'd50, 1'b1);
    run(7, 12'd50, 1'b1);
    chk("t10_auto_before", 32'(auto_trig), 0);
    chk("t10_busy", 32'(busy), 1);
    step(1'b0, 1'b1, 12'd50, 1'b1);
    chk("t10_auto_trig", 32'(auto_trig), 1);
    chk("t10_trig_addr", 32'(trig_addr), 0);
    chk("t10_start_addr", 32'(start_addr), 14);
    run(12, 12'd50, 1'b1);
    chk("t10_done_early", 32'(done), 0);
    run(1, 12'd50, 1'b1);
    chk("t10_done", 32'(done), 1);
    chk("t10_auto_held", 32'(auto_trig), 1);
    arm_capture(4'd2);
    chk("t10_auto_cleared", 32'(auto_trig), 0);
`else
    arm_capture(4'd2);
    run(2, 12'd50, 1'b1);
    run(12, 12'd50, 1'b1);
    chk("t10_busy", 32'(busy), 1);
    chk("t10_done", 32'(done), 0);
    chk("t10_auto_trig", 32'(auto_trig), 0);
    chk("t10_trig_addr", 32'(trig_addr), 8);
`endif

    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
